uart_host_bridge: RTL and testbench
===================================

Name: uart_host_bridge

Overview:
- CPU-side initiator for the UART's packed 32-bit AXI-lite-style register bus; the UART block is the responder.
- Accepts one byte-wide register read or write per request from the core over a valid/ready port.
- Packs the request onto the CPU_to_UART word, sequences the address/data/response handshakes, and unpacks the UART_to_CPU word.
- Returns data and status to the core; a timeout guards against a hung responder.

Parameters:
TIMEOUT_CYCLES, 256, cycles allowed from request issue to response capture before abort; must be ≥2
TO_WIDTH, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-high reset
req_valid_i  in  1  core request valid
req_ready_o  out  1  bridge can accept a request (high only in IDLE)
req_write_i  in  1  1=write, 0=read
req_addr_i  in  3  UART register address
req_wdata_i  in  8  write byte
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  core accepts response
rsp_rdata_o  out  8  read byte (0 for writes)
rsp_resp_o  out  2  00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR/timeout
rsp_timeout_o  out  1  response produced by timeout abort
CPU_to_UART  out  32  packed: [0]awvalid [1]wvalid [4:2]awaddr [5]bready [13:6]wdata [15]arvalid [18:16]araddr [19]rready; all other bits 0
UART_to_CPU  in  32  packed: [0]awready [1]wready [2]bvalid [4:3]bresp [5]arready [6]rvalid [8:7]rresp [16:9]rdata; other bits ignored

Behaviour:
- Clock/reset: single clock clk_i. rst_i is synchronous and active-high; it is sampled only on the rising edge of clk_i.
- Outputs: all are registered. On reset, all outputs are 0 except req_ready_o=1, and the FSM enters IDLE.
- Reset mid-transaction: aborts immediately. All bus valids/readies drop the next cycle; no response is generated.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: on req_valid_i&&req_ready_o (cycle N), latch write flag, addr, and wdata.
  - Write → WR_ADDR_DATA; awvalid=wvalid=1 from N+1.
  - Read → RD_ADDR; arvalid=1 from N+1.
  - Timeout counter clears on entry.
- Bus address/data fields: awaddr/araddr/wdata hold the latched values for the whole transaction and are 0 in IDLE.
- WR_ADDR_DATA: awvalid and wvalid retire independently. Each drops the cycle after its own ready is sampled high while valid. When both have handshaken (same or different cycles) → WR_RESP.
- WR_RESP: bready=1. On bvalid sampled high, capture bresp, rdata=0 → RSP. bvalid seen outside WR_RESP is ignored.
- RD_ADDR: arvalid=1 until arready is sampled high → RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata and rresp → RSP.
- RSP: rsp_valid_o=1 with stable data until rsp_ready_i → IDLE. req_ready_o returns to 1 the following cycle; no back-to-back overlap.
- Minimum latency with a responder giving arready high at N+1 and rvalid at N+2: rsp_valid_o at N+3. Write with all readies immediate and bvalid at N+2: rsp_valid_o at N+3.
- Timeout:
  - Counter increments every cycle in WR_ADDR_DATA/WR_RESP/RD_ADDR/RD_DATA and saturates.
  - When it reaches TIMEOUT_CYCLES, the transaction aborts: all bus valids/readies drop next cycle.
  - Response is rsp_resp_o=11, rsp_timeout_o=1, rdata=0 → RSP.
  - A handshake completing in the same cycle as expiry wins; no timeout.
- Core handshake: req_valid_i is ignored outside IDLE. rsp_timeout_o is 0 for normal completions.
- Bus rule: bready/rready are never asserted outside their states.

Test Plan:
- Reset: hold rst_i 2 cycles mid-read (arvalid=1) → next cycle CPU_to_UART=0, req_ready_o=1, rsp_valid_o=0.
- Write LCR: req write addr 3, data 8'h83; responder awready=wready=1, bvalid at N+2 with bresp 00 → CPU_to_UART[4:2]=3, [13:6]=8'h83 at N+1; rsp_valid_o at N+3, rsp_resp_o=00.
- Split write: awready at N+1, wready delayed to N+4 → awvalid low from N+2, wvalid high through N+4, bready high from N+5.
- Read SPR: addr 7, responder arready=1, rvalid at N+2 with rdata 8'h5A, rresp 00 → rsp_valid_o at N+3, rsp_rdata_o=8'h5A.
- Backpressure: rsp_ready_i low 5 cycles → rsp_* stable throughout, req_ready_o=0; IDLE one cycle after accept.
- Timeout: TIMEOUT_CYCLES=8, arready never asserted → arvalid drops, rsp_resp_o=11, rsp_timeout_o=1, rsp_rdata_o=0.

Source files
------------

// File: rtl/uart_host_bridge.sv
// uart_host_bridge: CPU-side initiator for the UART's packed AXI-lite-style
// register bus. It takes one byte-wide register read or write from the core,
// runs the address/data/response handshakes, and hands the result back.
// A saturating cycle counter aborts a transaction when the responder hangs.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_valid_i/req_ready_o  core request handshake (ready only in IDLE)
//   req_write_i/addr/wdata   request: 1=write, 3-bit register address, byte
//   rsp_valid_o/rsp_ready_i  core response handshake
//   rsp_rdata_o/resp/timeout read byte, AXI response code, timeout flag
//   CPU_to_UART              packed request-side bus word (bridge -> UART)
//   UART_to_CPU              packed response-side bus word (UART -> bridge)
module uart_host_bridge #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [2:0]  req_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [7:0]  rsp_rdata_o,
  output logic [1:0]  rsp_resp_o,
  output logic        rsp_timeout_o,
  output logic [31:0] CPU_to_UART,
  input  logic [31:0] UART_to_CPU
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP
  } state_t;

  localparam logic [TO_WIDTH-1:0] TO_MAX = TO_WIDTH'(TIMEOUT_CYCLES);

  state_t              state_q;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [2:0]          awaddr_q, araddr_q;
  logic [7:0]          wdata_q;
  logic                req_ready_q, rsp_valid_q, rsp_timeout_q;
  logic [7:0]          rsp_rdata_q;
  logic [1:0]          rsp_resp_q;

  // Unpacked responder signals
  logic       awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [7:0] rdata;
  logic       unused_bits;

  assign awready     = UART_to_CPU[0];
  assign wready      = UART_to_CPU[1];
  assign bvalid      = UART_to_CPU[2];
  assign bresp       = UART_to_CPU[4:3];
  assign arready     = UART_to_CPU[5];
  assign rvalid      = UART_to_CPU[6];
  assign rresp       = UART_to_CPU[8:7];
  assign rdata       = UART_to_CPU[16:9];
  assign unused_bits = ^UART_to_CPU[31:17];

  // Every output bit comes straight from a register.
  assign CPU_to_UART = {12'd0, rready_q, araddr_q, arvalid_q, 1'b0, wdata_q,
                        bready_q, awaddr_q, wvalid_q, awvalid_q};
  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_resp_o    = rsp_resp_q;
  assign rsp_timeout_o = rsp_timeout_q;

  // A channel counts as done once its valid has already dropped, so the two
  // write channels may retire in any order.
  logic aw_done, w_done, busy, adv, expire;
  assign aw_done = !awvalid_q || awready;
  assign w_done  = !wvalid_q  || wready;
  assign cnt_d   = (cnt_q == TO_MAX) ? cnt_q : cnt_q + 1'b1;
  assign expire  = (cnt_d == TO_MAX);

  // adv: the handshake that moves the current busy state forward this cycle.
  always_comb begin
    busy = 1'b1;
    adv  = 1'b0;
    case (state_q)
      WR_ADDR_DATA: adv = aw_done && w_done;
      WR_RESP:      adv = bvalid;
      RD_ADDR:      adv = arready;
      RD_DATA:      adv = rvalid;
      default:      busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else if (busy && expire && !adv) begin
      // Timeout abort; a handshake landing on the expiry cycle takes priority.
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= 1'b1;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b11;
      rsp_timeout_q <= 1'b1;
      state_q       <= RSP;
    end else begin
      if (busy) cnt_q <= cnt_d;
      case (state_q)
        IDLE: if (req_valid_i && req_ready_q) begin
          cnt_q       <= '0;
          req_ready_q <= 1'b0;
          if (req_write_i) begin
            awaddr_q  <= req_addr_i;
            wdata_q   <= req_wdata_i;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= WR_ADDR_DATA;
          end else begin
            araddr_q  <= req_addr_i;
            arvalid_q <= 1'b1;
            state_q   <= RD_ADDR;
          end
        end
        WR_ADDR_DATA: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if (adv) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: if (bvalid) begin
          bready_q      <= 1'b0;
          rsp_valid_q   <= 1'b1;
          rsp_rdata_q   <= '0;
          rsp_resp_q    <= bresp;
          rsp_timeout_q <= 1'b0;
          state_q       <= RSP;
        end
        RD_ADDR: if (arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= RD_DATA;
        end
        RD_DATA: if (rvalid) begin
          rready_q      <= 1'b0;
          rsp_valid_q   <= 1'b1;
          rsp_rdata_q   <= rdata;
          rsp_resp_q    <= rresp;
          rsp_timeout_q <= 1'b0;
          state_q       <= RSP;
        end
        RSP: if (rsp_ready_i) begin
          rsp_valid_q   <= 1'b0;
          rsp_rdata_q   <= '0;
          rsp_resp_q    <= '0;
          rsp_timeout_q <= 1'b0;
          awaddr_q      <= '0;
          araddr_q      <= '0;
          wdata_q       <= '0;
          req_ready_q   <= 1'b1;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed bench for uart_host_bridge (TIMEOUT_CYCLES=8). The responder is
// driven cycle by cycle from the stimulus; expected words are hand-packed.
module tb_uart_host_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] c2u, u2c;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_host_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_resp_o(rsp_resp),
    .rsp_timeout_o(rsp_timeout),
    .CPU_to_UART(c2u), .UART_to_CPU(u2c)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [2:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b1; u2c = '0;
    tick(); tick();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_bus", c2u, 32'h0);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_resp", {29'd0, rsp_timeout, rsp_resp}, 32'd0);
    rst = 1'b0;

    // Reset in the middle of a read: arvalid up, then reset for two cycles.
    issue(1'b0, 3'd6, 8'h00);
    chk("mid_arvalid", c2u, 32'h0006_8000);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("mid_bus", c2u, 32'h0);
    chk("mid_ready", 32'(req_ready), 32'd1);
    chk("mid_rspv", 32'(rsp_valid), 32'd0);

    // Write LCR (addr 3, 0x83), all readies immediate, bvalid at N+2.
    u2c = 32'h3;
    issue(1'b1, 3'd3, 8'h83);                   // now in N+1
    chk("wr_bus_n1", c2u, 32'h0000_20CF);
    chk("wr_rdy_n1", 32'(req_ready), 32'd0);
    tick();                                     // N+2
    chk("wr_bready", c2u, 32'h0000_20EC);
    u2c = 32'h4;
    tick();                                     // N+3
    chk("wr_rspv", 32'(rsp_valid), 32'd1);
    chk("wr_rsp", {21'd0, rsp_timeout, rsp_resp, rsp_rdata}, 32'd0);
    chk("wr_bus_n3", c2u, 32'h0000_20CC);
    u2c = 32'h0;
    tick();                                     // back in IDLE
    chk("wr_idle_rdy", 32'(req_ready), 32'd1);
    chk("wr_idle_bus", c2u, 32'h0);

    // Split write: awready at N+1, wready at N+4, bresp SLVERR.
    issue(1'b1, 3'd1, 8'h3C);                   // N+1
    chk("sp_n1", {30'd0, c2u[1:0]}, 32'd3);
    u2c = 32'h1;
    tick();                                     // N+2
    chk("sp_n2", {26'd0, c2u[5], 3'd0, c2u[1:0]}, 32'd2);
    u2c = 32'h0;
    tick();                                     // N+3
    chk("sp_n3", {26'd0, c2u[5], 3'd0, c2u[1:0]}, 32'd2);
    tick();                                     // N+4
    chk("sp_n4", {26'd0, c2u[5], 3'd0, c2u[1:0]}, 32'd2);
    u2c = 32'h2;
    tick();                                     // N+5
    chk("sp_n5", {26'd0, c2u[5], 3'd0, c2u[1:0]}, 32'h20);
    u2c = 32'h14;
    tick();                                     // N+6
    chk("sp_rspv", 32'(rsp_valid), 32'd1);
    chk("sp_resp", 32'(rsp_resp), 32'd2);
    u2c = 32'h0;
    tick();

    // Read SPR (addr 7): arready at N+1, rvalid with 0x5A at N+2.
    issue(1'b0, 3'd7, 8'h00);                   // N+1
    chk("rd_n1", c2u, 32'h0007_8000);
    u2c = 32'h20;
    tick();                                     // N+2
    chk("rd_n2", c2u, 32'h000F_0000);
    u2c = 32'h0000_B440;
    tick();                                     // N+3
    chk("rd_rspv", 32'(rsp_valid), 32'd1);
    chk("rd_data", 32'(rsp_rdata), 32'h5A);
    chk("rd_resp", {29'd0, rsp_timeout, rsp_resp}, 32'd0);
    u2c = 32'h0;
    tick();

    // Backpressure: read addr 2 returning 0xA5/EXOKAY, core stalls 5 cycles
    // while also holding a new request that must be ignored.
    rsp_ready = 1'b0;
    issue(1'b0, 3'd2, 8'h00);
    u2c = 32'h20; tick();
    u2c = 32'h0001_4AC0; tick();
    u2c = 32'h0;
    req_valid = 1'b1; req_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {12'd0, rsp_valid, req_ready, rsp_timeout, rsp_resp, rsp_rdata, 7'd0},
          {12'd0, 1'b1, 1'b0, 1'b0, 2'd1, 8'hA5, 7'd0});
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_release", {30'd0, rsp_valid, req_ready}, 32'd1);
    req_valid = 1'b0;
    tick();

    // Timeout: read addr 4, arready never comes; abort after 8 busy cycles.
    issue(1'b0, 3'd4, 8'h00);                   // N+1
    chk("to_n1", 32'(c2u[15]), 32'd1);
    for (int i = 0; i < 7; i++) tick();         // N+8
    chk("to_n8", {31'd0, c2u[15]}, 32'd1);
    chk("to_n8_rspv", 32'(rsp_valid), 32'd0);
    tick();                                     // N+9
    chk("to_rspv", 32'(rsp_valid), 32'd1);
    chk("to_rsp", {21'd0, rsp_timeout, rsp_resp, rsp_rdata}, 32'h0000_0700);
    chk("to_bus", {30'd0, c2u[19], c2u[15]}, 32'd0);
    tick();
    chk("to_idle", 32'(req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
